// File: rtl/gato_pkg.sv
// Shared definitions for the Gato board: cell codes, FSM encoding, defaults.
package gato_pkg;

   localparam int unsigned CELDAS_DEF = 9;
   localparam int unsigned ANCHO_DEF  = 2;
   localparam int unsigned CNT_W_DEF  = 4;
   localparam int unsigned CODIGO_W   = 2;

   // Cell codes; 2'b11 is never written.
   localparam logic [CODIGO_W-1:0] VACIO = 2'b00;
   localparam logic [CODIGO_W-1:0] X     = 2'b01;
   localparam logic [CODIGO_W-1:0] O     = 2'b10;

   typedef enum logic [1:0] {
      ESPERA = 2'd0,
      VALIDA = 2'd1,
      LLENO  = 2'd2
   } estado_e;

endpackage

// File: rtl/registro_tablero_if.sv
// Move-request / board-state bundle between the input decoder and the board.
interface registro_tablero_if
   import gato_pkg::*;
#(
   parameter int unsigned CELDAS = CELDAS_DEF,
   parameter int unsigned ANCHO  = ANCHO_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) ();

   logic                     mover;
   logic [CNT_W-1:0]         posicion;
   logic                     limpiar;
   logic [CELDAS*ANCHO-1:0]  tablero;
   logic                     turno;
   logic                     ack;
   logic                     rechazo;
   logic                     ocupado;
   logic                     lleno;
   logic [CNT_W-1:0]         num_jugadas;

   modport master (
      output mover, posicion, limpiar,
      input  tablero, turno, ack, rechazo, ocupado, lleno, num_jugadas
   );

   modport slave (
      input  mover, posicion, limpiar,
      output tablero, turno, ack, rechazo, ocupado, lleno, num_jugadas
   );

endinterface

// File: rtl/registro_celda.sv
// One board cell: ANCHO-bit register with async reset, sync clear and load.
module registro_celda
   import gato_pkg::*;
#(
   parameter int unsigned ANCHO = ANCHO_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             limpiar,
   input  logic             carga,
   input  logic [ANCHO-1:0] dato,
   output logic [ANCHO-1:0] valor
);

   // Clear wins over load so a new game never keeps a stale mark.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         valor <= ANCHO'(VACIO);
      else if (limpiar)
         valor <= ANCHO'(VACIO);
      else if (carga)
         valor <= dato;
   end

endmodule

// File: rtl/registro_tablero.sv
// Gato board register: validates move requests, writes marks, alternates turn,
// counts moves and flags a full board.
module registro_tablero
   import gato_pkg::*;
#(
   parameter int unsigned CELDAS = CELDAS_DEF,
   parameter int unsigned ANCHO  = ANCHO_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   registro_tablero_if.slave   bus
);

   estado_e                 estado;
   estado_e                 estado_sig;
   logic [CNT_W-1:0]        pos_lat;
   logic [CNT_W-1:0]        pos_sig;
   logic                    turno_sig;
   logic [CNT_W-1:0]        num_sig;
   logic                    lleno_sig;
   logic                    ack_sig;
   logic                    rechazo_sig;
   logic                    escribir;
   logic                    fuera;
   logic                    ocupada;
   logic [ANCHO-1:0]        marca;
   logic [CNT_W-1:0]        num_mas_uno;
   logic [CELDAS*ANCHO-1:0] celdas;

   assign bus.tablero = celdas;
   assign marca       = bus.turno ? ANCHO'(O) : ANCHO'(X);
   assign num_mas_uno = bus.num_jugadas + CNT_W'(1);
   assign fuera       = (pos_lat >= CNT_W'(CELDAS));

   // Occupancy of the latched target cell; out-of-range targets match no cell.
   always_comb begin
      ocupada = 1'b0;
      for (int unsigned i = 0; i < CELDAS; i++) begin
         if (pos_lat == CNT_W'(i))
            ocupada = (celdas[i*ANCHO +: ANCHO] != ANCHO'(VACIO));
      end
   end

   // State register and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado          <= ESPERA;
         pos_lat         <= '0;
         bus.turno       <= 1'b0;
         bus.num_jugadas <= '0;
         bus.lleno       <= 1'b0;
         bus.ack         <= 1'b0;
         bus.rechazo     <= 1'b0;
         bus.ocupado     <= 1'b0;
      end else begin
         estado          <= estado_sig;
         pos_lat         <= pos_sig;
         bus.turno       <= turno_sig;
         bus.num_jugadas <= num_sig;
         bus.lleno       <= lleno_sig;
         bus.ack         <= ack_sig;
         bus.rechazo     <= rechazo_sig;
         bus.ocupado     <= (estado_sig == VALIDA);
      end
   end

   // Next state, move validation and turn/counter update; limpiar overrides all.
   always_comb begin
      estado_sig  = estado;
      pos_sig     = pos_lat;
      turno_sig   = bus.turno;
      num_sig     = bus.num_jugadas;
      lleno_sig   = bus.lleno;
      ack_sig     = 1'b0;
      rechazo_sig = 1'b0;
      escribir    = 1'b0;

      if (bus.limpiar) begin
         estado_sig = ESPERA;
         turno_sig  = 1'b0;
         num_sig    = '0;
         lleno_sig  = 1'b0;
      end else begin
         case (estado)
            ESPERA: begin
               if (bus.mover) begin
                  pos_sig    = bus.posicion;
                  estado_sig = VALIDA;
               end
            end
            VALIDA: begin
               if (fuera || ocupada) begin
                  rechazo_sig = 1'b1;
                  estado_sig  = ESPERA;
               end else begin
                  escribir  = 1'b1;
                  ack_sig   = 1'b1;
                  num_sig   = num_mas_uno;
                  turno_sig = ~bus.turno;
                  if (num_mas_uno == CNT_W'(CELDAS)) begin
                     estado_sig = LLENO;
                     lleno_sig  = 1'b1;
                  end else begin
                     estado_sig = ESPERA;
                  end
               end
            end
            LLENO: begin
               if (bus.mover)
                  rechazo_sig = 1'b1;
            end
            default: begin
               estado_sig = ESPERA;
            end
         endcase
      end
   end

   // One register per cell; only the latched target loads on a legal move.
   for (genvar g = 0; g < CELDAS; g++) begin : g_celda
      registro_celda #(
         .ANCHO (ANCHO)
      ) u_celda (
         .clk     (clk),
         .reset   (reset),
         .limpiar (bus.limpiar),
         .carga   (escribir && (pos_lat == CNT_W'(g))),
         .dato    (marca),
         .valor   (celdas[g*ANCHO +: ANCHO])
      );
   end

endmodule

// File: tb/tb_registro_tablero.sv
// Scoreboard bench for registro_tablero: stimulus pushes expected responses,
// a monitor pops and compares on every ack/rechazo pulse.
module tb_registro_tablero;

   localparam int unsigned CELDAS = 9;
   localparam int unsigned ANCHO  = 2;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned TW     = CELDAS * ANCHO;

   typedef struct packed {
      logic          es_ack;
      logic [TW-1:0] tablero;
      logic          turno;
      logic [3:0]    num;
      logic          lleno;
   } resp_t;

   logic clk;
   logic reset;

   registro_tablero_if #(.CELDAS(CELDAS), .ANCHO(ANCHO), .CNT_W(CNT_W)) bus ();

   registro_tablero #(
      .CELDAS (CELDAS),
      .ANCHO  (ANCHO),
      .CNT_W  (CNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   resp_t      sb[$];
   int         compared   = 0;
   int         mismatched = 0;

   logic [1:0] m_cel [CELDAS];
   logic       m_turno;
   logic [3:0] m_num;
   logic       m_lleno;

   task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", nombre, act, req);
      end
   endtask

   function automatic logic [TW-1:0] m_tablero();
      logic [TW-1:0] t;
      t = '0;
      for (int i = 0; i < CELDAS; i++) t[i*ANCHO +: ANCHO] = m_cel[i];
      return t;
   endfunction

   task automatic m_limpiar();
      for (int i = 0; i < CELDAS; i++) m_cel[i] = 2'b00;
      m_turno = 1'b0;
      m_num   = '0;
      m_lleno = 1'b0;
   endtask

   // Monitor: every response pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!reset && (bus.ack || bus.rechazo)) begin
         resp_t e;
         if (bus.ack && bus.rechazo) chk("ack_and_rechazo", 32'd1, 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_pulse", {30'd0, bus.ack, bus.rechazo}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("resp_kind",    32'(bus.ack),         32'(e.es_ack));
            chk("resp_tablero", 32'(bus.tablero),     32'(e.tablero));
            chk("resp_turno",   32'(bus.turno),       32'(e.turno));
            chk("resp_num",     32'(bus.num_jugadas), 32'(e.num));
            chk("resp_lleno",   32'(bus.lleno),       32'(e.lleno));
         end
      end
   end

   // Issue one move request; exp_ack is the hand-derived legality verdict.
   task automatic mover_a(input logic [3:0] pos, input logic exp_ack);
      resp_t e;
      logic  legal;
      logic  en_lleno;
      en_lleno = m_lleno;
      legal = !m_lleno && (pos < 4'(CELDAS)) && (m_cel[pos] == 2'b00);
      chk("verdict_table", 32'(legal), 32'(exp_ack));
      if (legal) begin
         m_cel[pos] = m_turno ? 2'b10 : 2'b01;
         m_turno    = ~m_turno;
         m_num      = m_num + 4'd1;
         if (m_num == 4'(CELDAS)) m_lleno = 1'b1;
      end
      e = '{es_ack: legal, tablero: m_tablero(), turno: m_turno, num: m_num, lleno: m_lleno};
      @(negedge clk);
      sb.push_back(e);
      bus.mover    = 1'b1;
      bus.posicion = pos;
      @(negedge clk);
      bus.mover = 1'b0;
      if (!en_lleno) chk("ocupado_valida", 32'(bus.ocupado), 32'd1);
      @(negedge clk);
      #1;
      chk("response_in_time", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic chk_estado(input string etiqueta);
      chk({etiqueta, "_tablero"}, 32'(bus.tablero),     32'(m_tablero()));
      chk({etiqueta, "_turno"},   32'(bus.turno),       32'(m_turno));
      chk({etiqueta, "_num"},     32'(bus.num_jugadas), 32'(m_num));
      chk({etiqueta, "_lleno"},   32'(bus.lleno),       32'(m_lleno));
   endtask

   task automatic pulso_limpiar();
      @(negedge clk);
      bus.limpiar = 1'b1;
      @(negedge clk);
      bus.limpiar = 1'b0;
      m_limpiar();
   endtask

   // Directed move list for the full-board game: X at 4,8,6,5,7; O at 0,2,3,1.
   logic [3:0] partida [9] = '{4'd4, 4'd0, 4'd8, 4'd2, 4'd6, 4'd3, 4'd5, 4'd1, 4'd7};

   initial begin
      reset        = 1'b1;
      bus.mover    = 1'b0;
      bus.posicion = '0;
      bus.limpiar  = 1'b0;
      m_limpiar();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      chk("rst_tablero", 32'(bus.tablero),     32'd0);
      chk("rst_turno",   32'(bus.turno),       32'd0);
      chk("rst_num",     32'(bus.num_jugadas), 32'd0);
      chk("rst_lleno",   32'(bus.lleno),       32'd0);
      chk("rst_ack",     32'(bus.ack),         32'd0);
      chk("rst_rechazo", 32'(bus.rechazo),     32'd0);
      chk("rst_ocupado", 32'(bus.ocupado),     32'd0);

      mover_a(4'd4, 1'b1);
      chk("first_move_board", 32'(bus.tablero), 32'h00100);
      chk("first_move_turno", 32'(bus.turno),   32'd1);
      mover_a(4'd4, 1'b0);
      chk_estado("after_dup");
      mover_a(4'd9, 1'b0);
      chk_estado("after_range");
      mover_a(4'd15, 1'b0);
      chk_estado("after_range15");

      pulso_limpiar();
      chk_estado("after_limpiar");

      for (int i = 0; i < 9; i++) mover_a(partida[i], 1'b1);
      chk("full_board",  32'(bus.tablero),     32'h155AA);
      chk("full_lleno",  32'(bus.lleno),       32'd1);
      chk("full_num",    32'(bus.num_jugadas), 32'd9);
      mover_a(4'd0, 1'b0);
      chk_estado("after_tenth");

      pulso_limpiar();
      chk_estado("clear_from_lleno");

      // limpiar lands while the request sits in VALIDA: request is dropped.
      @(negedge clk);
      bus.mover    = 1'b1;
      bus.posicion = 4'd2;
      @(negedge clk);
      bus.mover = 1'b0;
      chk("ocupado_before_drop", 32'(bus.ocupado), 32'd1);
      bus.limpiar = 1'b1;
      @(negedge clk);
      bus.limpiar = 1'b0;
      repeat (2) @(negedge clk);
      chk_estado("drop_valida");
      chk("drop_ocupado", 32'(bus.ocupado), 32'd0);
      mover_a(4'd2, 1'b1);

      // Async reset between edges while a request is in VALIDA.
      mover_a(4'd6, 1'b1);
      @(negedge clk);
      bus.mover    = 1'b1;
      bus.posicion = 4'd7;
      @(negedge clk);
      bus.mover = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_tablero", 32'(bus.tablero),     32'd0);
      chk("arst_turno",   32'(bus.turno),       32'd0);
      chk("arst_num",     32'(bus.num_jugadas), 32'd0);
      chk("arst_ocupado", 32'(bus.ocupado),     32'd0);
      chk("arst_ack",     32'(bus.ack),         32'd0);
      m_limpiar();
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      chk_estado("post_arst");
      mover_a(4'd7, 1'b1);
      chk("post_arst_move", 32'(bus.tablero), 32'h04000);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no end expected end");
      $fatal(1);
   end

endmodule
